// File: rtl/button_debounce.sv
// Multi-channel pin synchronizer and debouncer: clean active-high levels plus
// one-cycle press/release pulses for a downstream PIO input port.
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_pressed
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [WIDTH-1:0] norm;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic             any_q, any_d;

  // Normalised "pressed" level; sync stages idle at 0, i.e. the inactive pin level.
  assign norm = raw_in ^ {WIDTH{ACTIVE_LOW}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= norm;
      s2_q <= s1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             db_bit_d;

      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        db_bit_d = db_q[gi];
        case (state_q)
          STABLE: begin
            if (s2_q[gi] != db_q[gi]) begin
              state_d = PENDING;
              cnt_d   = CNT_W'(1);
            end else begin
              cnt_d = '0;
            end
          end
          PENDING: begin
            if (s2_q[gi] == db_q[gi]) begin
              state_d = STABLE;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              // Sample differed for DEBOUNCE_CYCLES consecutive edges: accept it.
              db_bit_d = ~db_q[gi];
              state_d  = STABLE;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        endcase
      end

      assign db_d[gi] = db_bit_d;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q <= STABLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end
    end
  endgenerate

  assign press_d   = db_d & ~db_q;
  assign release_d = ~db_d & db_q;
  assign any_d     = |db_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q      <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
    end
  end

  assign db_out        = db_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign any_pressed   = any_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench: directed scenarios plus random bouncing on an active-low
// and a pass-through instance, against a sliding-window reference model.
module tb_button_debounce;
  localparam int W = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw0, raw1;
  logic [W-1:0] db0, pr0, rl0, db1, pr1, rl1;
  logic         any0, any1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset_n(reset_n), .raw_in(raw0),
    .db_out(db0), .press_pulse(pr0), .release_pulse(rl0), .any_pressed(any0));

  button_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .reset_n(reset_n), .raw_in(raw1),
    .db_out(db1), .press_pulse(pr1), .release_pulse(rl1), .any_pressed(any1));

  // Model: a level is accepted once the last D synchronized samples (pin value
  // from two edges earlier) all disagree with the current debounced level.
  logic [W-1:0] m_p0[2], m_p1[2], m_db[2], m_pr[2], m_rl[2];
  logic [W-1:0] m_hist[2][D];

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_p0[n] = '0; m_p1[n] = '0; m_db[n] = '0; m_pr[n] = '0; m_rl[n] = '0;
      for (int k = 0; k < D; k++) m_hist[n][k] = '0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] nrm, smp, tog;
    for (int n = 0; n < 2; n++) begin
      nrm = (n == 0) ? ~raw0 : raw1;
      smp = m_p1[n];
      m_p1[n] = m_p0[n];
      m_p0[n] = nrm;
      for (int k = D - 1; k > 0; k--) m_hist[n][k] = m_hist[n][k-1];
      m_hist[n][0] = smp;
      tog = '1;
      for (int c = 0; c < W; c++)
        for (int k = 0; k < D; k++)
          if (m_hist[n][k][c] == m_db[n][c]) tog[c] = 1'b0;
      m_pr[n] = tog & ~m_db[n];
      m_rl[n] = tog & m_db[n];
      m_db[n] = m_db[n] ^ tog;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("db_al",  32'(db0),  32'(m_db[0]));
    chk("pr_al",  32'(pr0),  32'(m_pr[0]));
    chk("rl_al",  32'(rl0),  32'(m_rl[0]));
    chk("any_al", 32'(any0), 32'(|m_db[0]));
    chk("db_ah",  32'(db1),  32'(m_db[1]));
    chk("pr_ah",  32'(pr1),  32'(m_pr[1]));
    chk("rl_ah",  32'(rl1),  32'(m_rl[1]));
    chk("any_ah", 32'(any1), 32'(|m_db[1]));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset asserted mid-cycle, pins returned to idle meanwhile.
  task automatic mid_reset(input int hold);
    #2;
    reset_n = 1'b0;
    raw0 = '1;
    raw1 = '0;
    model_reset();
    #1;
    compare_all();
    cycles(hold);
    reset_n = 1'b1;
  endtask

  initial begin
    int b;
    reset_n = 1'b0;
    raw0 = 4'hF;
    raw1 = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    $display("step: idle after reset, 100 cycles");
    cycles(100);

    $display("step: clean press/release ch0 on both instances");
    raw0 = 4'hE; raw1 = 4'h1;
    cycles(9);
    chk("press_early_db", 32'(db0[0]), 32'd0);
    cycle();
    chk("press_edge10_db", 32'(db0[0]), 32'd1);
    chk("press_edge10_pulse", 32'(pr0), 32'h1);
    chk("ah_edge10_db", 32'(db1[0]), 32'd1);
    cycle();
    chk("press_one_cycle", 32'(pr0[0]), 32'd0);
    cycles(10);
    raw0 = 4'hF; raw1 = 4'h0;
    cycles(9);
    chk("release_early_db", 32'(db0[0]), 32'd1);
    cycle();
    chk("release_edge10_pulse", 32'(rl0), 32'h1);
    chk("release_edge10_db", 32'(db0[0]), 32'd0);
    cycles(5);

    $display("step: glitch 7 cycles on ch1 rejected, 8 cycles accepted");
    raw0 = 4'hD;
    cycles(7);
    raw0 = 4'hF;
    cycles(12);
    chk("glitch7_db", 32'(db0[1]), 32'd0);
    raw0 = 4'hD;
    cycles(8);
    raw0 = 4'hF;
    cycles(2);
    chk("glitch8_db", 32'(db0[1]), 32'd1);
    chk("glitch8_pulse", 32'(pr0), 32'h2);
    cycles(15);

    $display("step: bounce on ch2 then hold");
    raw0 = 4'hB; cycles(3);
    raw0 = 4'hF; cycles(3);
    raw0 = 4'hB;
    cycles(9);
    chk("bounce_early_db", 32'(db0[2]), 32'd0);
    cycle();
    chk("bounce_pulse", 32'(pr0), 32'h4);
    raw0 = 4'hF;
    cycles(15);

    $display("step: ch0+ch3 together, then reset mid-count");
    raw0 = 4'h6;
    cycles(10);
    chk("multi_pulse", 32'(pr0), 32'h9);
    chk("multi_any", 32'(any0), 32'd1);
    raw0 = 4'h2;
    cycles(7);
    mid_reset(3);
    chk("reset_db", 32'(db0), 32'd0);
    chk("reset_any", 32'(any0), 32'd0);
    cycles(30);

    $display("step: random bouncing, 3000 cycles");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, W - 1);
        raw0[b] = ~raw0[b];
      end
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, W - 1);
        raw1[b] = ~raw1[b];
      end
      if ($urandom_range(0, 999) == 0) mid_reset(2);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
